// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid.
// Supports a hazard stall that freezes the stage and a flush that injects a bubble.
module pipe_stage_buffer #(
   parameter int                DATA_W      = 64,
   parameter logic [DATA_W-1:0] BUBBLE_DATA = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   // state | meaning
   // EMPTY | no entries held, out_valid low
   // ONE   | main register holds the live entry
   // FULL  | main holds the oldest entry, skid holds the next one
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              pop;
   logic              accept;

   assign in_ready  = (state_q != FULL) & ~stall & ~reset;
   assign out_valid = (state_q != EMPTY);
   assign pop       = out_valid & out_ready & ~stall;
   assign accept    = in_valid & in_ready;
   assign out_data  = main_q;
   assign occupancy = state_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE_DATA;
         skid_d  = BUBBLE_DATA;
      end else if (!stall) begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_d = in_data;
               end else if (accept) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= BUBBLE_DATA;
         skid_q  <= BUBBLE_DATA;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(pop && state_q == EMPTY));
         assert (!(accept && state_q == FULL));
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed test of pipe_stage_buffer: streaming, skid backpressure, stall, flush, reset.
module tb_pipe_stage_buffer;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          stall;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   int total = 0;
   int bad   = 0;

   pipe_stage_buffer #(.DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic st, input logic fl, input logic rs);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      stall     = st;
      flush     = fl;
      reset     = rs;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                          input logic [1:0] occ);
      chk({tag, ".valid"}, out_valid, v);
      if (v) chk({tag, ".data"}, out_data, d);
      chk({tag, ".occ"}, occupancy, occ);
   endtask

   task automatic chk_bubble(input string tag);
      chk({tag, ".valid"}, out_valid, 1'b0);
      chk({tag, ".data"}, out_data, '0);
      chk({tag, ".occ"}, occupancy, 2'd0);
   endtask

   initial begin
      // Test 1: reset then stream
      @(negedge clk);
      drive(1'b1, 64'h99, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("rst.in_ready", in_ready, 1'b0);
      tick();
      chk("rst.in_ready2", in_ready, 1'b0);
      tick();
      chk_bubble("rst");
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst.release_ready", in_ready, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, 1'b0);
         chk($sformatf("stream%0d.in_ready", i), in_ready, 1'b1);
         tick();
         chk_out($sformatf("stream%0d", i), 1'b1, DW'(i), 2'd1);
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("stream.drain", 1'b0, '0, 2'd0);

      // Test 2: backpressure into the skid
      drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("bp.pushA", 1'b1, 64'hA, 2'd1);
      drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp.ready_one", in_ready, 1'b1);
      tick();
      chk_out("bp.pushB", 1'b1, 64'hA, 2'd2);
      drive(1'b1, 64'hC, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bp.ready_full", in_ready, 1'b0);
      tick();
      chk_out("bp.holdC", 1'b1, 64'hA, 2'd2);
      drive(1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("bp.ready_full_pop", in_ready, 1'b0);
      tick();
      chk_out("bp.popA", 1'b1, 64'hB, 2'd1);
      drive(1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("bp.ready_after_pop", in_ready, 1'b1);
      tick();
      chk_out("bp.popB", 1'b1, 64'hC, 2'd1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("bp.popC", 1'b0, '0, 2'd0);

      // Test 3: stall holds a FULL stage
      drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("st.full", 1'b1, 64'hA, 2'd2);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
         chk($sformatf("st%0d.in_ready", i), in_ready, 1'b0);
         tick();
         chk_out($sformatf("st%0d", i), 1'b1, 64'hA, 2'd2);
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("st.popA", 1'b1, 64'hB, 2'd1);
      tick();
      chk_out("st.popB", 1'b0, '0, 2'd0);

      // Stall in ONE must also block accept
      drive(1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'h22, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("st_one.in_ready", in_ready, 1'b0);
      tick();
      chk_out("st_one", 1'b1, 64'h11, 2'd1);

      // Test 4: flush with stall in FULL
      drive(1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("fl.full", 1'b1, 64'h11, 2'd2);
      drive(1'b1, 64'hD, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      chk_bubble("fl.stall");
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_bubble("fl.noD");

      // Flush in ONE discards the beat accepted in the flush cycle
      drive(1'b1, 64'h33, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'hE, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fl_one.in_ready", in_ready, 1'b1);
      tick();
      chk_bubble("fl.one");
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_bubble("fl.noE");

      // Test 5: reset mid-operation
      drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("mr.full", 1'b1, 64'hA, 2'd2);
      drive(1'b1, 64'h7, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("mr.in_ready", in_ready, 1'b0);
      tick();
      chk_bubble("mr.after");
      drive(1'b1, 64'h5, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mr.ready_after", in_ready, 1'b1);
      tick();
      chk_out("mr.push5", 1'b1, 64'h5, 2'd1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("mr.alone", 1'b0, '0, 2'd0);

      // Mixed sequence: ONE->FULL, FULL pop, ONE accept&pop, ONE pop
      drive(1'b1, 64'h41, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 64'h42, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("mx.pop41", 1'b1, 64'h42, 2'd1);
      drive(1'b1, 64'h43, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("mx.pop42", 1'b1, 64'h43, 2'd1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("mx.hold43", 1'b1, 64'h43, 2'd1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("mx.pop43", 1'b0, '0, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
